// File: rtl/flopr_univ.sv
// flopr_univ: universal register with load, shift, rotate and count modes.
// Registered shift-out/carry flag plus combinational zero detect.
module flopr_univ #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             zero
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_INC  = 3'b110,
    M_DEC  = 3'b111
  } mode_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_nxt;
  logic             co_nxt;
  mode_t            op;

  assign op = mode_t'(mode);

  // Next value of q/co for the selected operation when enabled.
  always_comb begin
    q_nxt  = q;
    co_nxt = co;
    unique case (op)
      M_HOLD: begin
        q_nxt  = q;
        co_nxt = co;
      end
      M_LOAD: begin
        q_nxt  = d;
        co_nxt = 1'b0;
      end
      M_SHL: begin
        q_nxt  = {q[WIDTH-2:0], sin};
        co_nxt = q[WIDTH-1];
      end
      M_SHR: begin
        q_nxt  = {sin, q[WIDTH-1:1]};
        co_nxt = q[0];
      end
      M_ROL: begin
        q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
        co_nxt = q[WIDTH-1];
      end
      M_ROR: begin
        q_nxt  = {q[0], q[WIDTH-1:1]};
        co_nxt = q[0];
      end
      M_INC: begin
        q_nxt  = q + ONE;
        co_nxt = &q;
      end
      M_DEC: begin
        q_nxt  = q - ONE;
        co_nxt = ~|q;
      end
      default: begin
        q_nxt  = q;
        co_nxt = co;
      end
    endcase
  end

  // State register: async reset, then clear, then enabled operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q  <= RESET_VAL;
      co <= 1'b0;
    end else if (clr) begin
      q  <= RESET_VAL;
      co <= 1'b0;
    end else if (en) begin
      q  <= q_nxt;
      co <= co_nxt;
    end
  end

  assign zero = (q == '0);

endmodule

// File: tb/tb_flopr_univ.sv
// tb_flopr_univ: directed tests for flopr_univ.
// Covers a 4-bit default instance and an 8-bit RESET_VAL=6 instance.
module tb_flopr_univ;

  logic       clk = 1'b0;
  logic       reset, en, clr, sin;
  logic [2:0] mode;
  logic [3:0] d, q;
  logic       co, zero;

  logic       reset8, en8, clr8, sin8;
  logic [2:0] mode8;
  logic [7:0] d8, q8;
  logic       co8, zero8;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  flopr_univ dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .mode(mode), .d(d), .sin(sin),
    .q(q), .co(co), .zero(zero)
  );

  flopr_univ #(.WIDTH(8), .RESET_VAL(8'h06)) dut8 (
    .clk(clk), .reset(reset8), .en(en8), .clr(clr8),
    .mode(mode8), .d(d8), .sin(sin8),
    .q(q8), .co(co8), .zero(zero8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; clr = 1'b0;
    mode = 3'b001; d = 4'hF; sin = 1'b0;
    reset8 = 1'b0; en8 = 1'b0; clr8 = 1'b0;
    mode8 = 3'b000; d8 = 8'h00; sin8 = 1'b0;
    #1;
    nchecks++;
    if ({q, co, zero} !== {4'h0, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL reset_t0: got q=%h co=%b z=%b want q=0 co=0 z=1",
               q, co, zero);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      nchecks++;
      if ({q, co, zero} !== {4'h0, 1'b0, 1'b1}) begin
        nerr++;
        $display("FAIL reset_hold%0d: got q=%h co=%b z=%b want q=0 co=0 z=1",
                 i, q, co, zero);
      end
    end
    reset = 1'b1;
    tick();
    nchecks++;
    if ({q, co, zero} !== {4'hF, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_release: got q=%h co=%b z=%b want q=f co=0 z=0",
               q, co, zero);
    end
  endtask

  task automatic test_load_hold();
    mode = 3'b001; d = 4'hA; en = 1'b1;
    tick();
    nchecks++;
    if ({q, co} !== {4'hA, 1'b0}) begin
      nerr++;
      $display("FAIL load_a: got q=%h co=%b want q=a co=0", q, co);
    end
    en = 1'b0; d = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      nchecks++;
      if (q !== 4'hA) begin
        nerr++;
        $display("FAIL en_hold%0d: got q=%h want q=a", i, q);
      end
    end
    clr = 1'b1;
    tick();
    nchecks++;
    if ({q, co, zero} !== {4'h0, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL clr_no_en: got q=%h co=%b z=%b want q=0 co=0 z=1",
               q, co, zero);
    end
    clr = 1'b0; en = 1'b1;
  endtask

  task automatic test_shift();
    mode = 3'b001; d = 4'b1001;
    tick();
    mode = 3'b010; sin = 1'b0;
    tick();
    nchecks++;
    if ({q, co} !== {4'b0010, 1'b1}) begin
      nerr++;
      $display("FAIL shl: got q=%b co=%b want q=0010 co=1", q, co);
    end
    mode = 3'b011; sin = 1'b1;
    tick();
    nchecks++;
    if ({q, co} !== {4'b1001, 1'b0}) begin
      nerr++;
      $display("FAIL shr_s1: got q=%b co=%b want q=1001 co=0", q, co);
    end
    sin = 1'b0;
    tick();
    nchecks++;
    if ({q, co} !== {4'b0100, 1'b1}) begin
      nerr++;
      $display("FAIL shr_s0: got q=%b co=%b want q=0100 co=1", q, co);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_q [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    logic       exp_c [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    mode = 3'b001; d = 4'b1000; sin = 1'b1;
    tick();
    mode = 3'b100;
    tick();
    nchecks++;
    if ({q, co} !== {4'b0001, 1'b1}) begin
      nerr++;
      $display("FAIL rol1: got q=%b co=%b want q=0001 co=1", q, co);
    end
    mode = 3'b101;
    tick();
    nchecks++;
    if ({q, co} !== {4'b1000, 1'b1}) begin
      nerr++;
      $display("FAIL ror1: got q=%b co=%b want q=1000 co=1", q, co);
    end
    tick();
    nchecks++;
    if ({q, co} !== {4'b0100, 1'b0}) begin
      nerr++;
      $display("FAIL ror2: got q=%b co=%b want q=0100 co=0", q, co);
    end
    mode = 3'b100;
    for (int i = 0; i < 4; i++) begin
      tick();
      nchecks++;
      if ({q, co} !== {exp_q[i], exp_c[i]}) begin
        nerr++;
        $display("FAIL rol_loop%0d: got q=%b co=%b want q=%b co=%b",
                 i, q, co, exp_q[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_count();
    mode = 3'b001; d = 4'hE;
    tick();
    mode = 3'b110;
    tick();
    nchecks++;
    if ({q, co, zero} !== {4'hF, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL inc_f: got q=%h co=%b z=%b want q=f co=0 z=0",
               q, co, zero);
    end
    tick();
    nchecks++;
    if ({q, co, zero} !== {4'h0, 1'b1, 1'b1}) begin
      nerr++;
      $display("FAIL inc_wrap: got q=%h co=%b z=%b want q=0 co=1 z=1",
               q, co, zero);
    end
    mode = 3'b111;
    tick();
    nchecks++;
    if ({q, co, zero} !== {4'hF, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL dec_wrap: got q=%h co=%b z=%b want q=f co=1 z=0",
               q, co, zero);
    end
    mode = 3'b000;
    tick();
    nchecks++;
    if ({q, co} !== {4'hF, 1'b1}) begin
      nerr++;
      $display("FAIL mode_hold: got q=%h co=%b want q=f co=1", q, co);
    end
    mode = 3'b111;
    tick();
    nchecks++;
    if ({q, co} !== {4'hE, 1'b0}) begin
      nerr++;
      $display("FAIL dec_e: got q=%h co=%b want q=e co=0", q, co);
    end
  endtask

  task automatic test_async_reset();
    mode = 3'b001; d = 4'h3;
    tick();
    mode = 3'b110;
    tick();
    nchecks++;
    if (q !== 4'h4) begin
      nerr++;
      $display("FAIL inc_3: got q=%h want q=4", q);
    end
    #2;
    reset = 1'b0;
    #1;
    nchecks++;
    if ({q, co, zero} !== {4'h0, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL async_rst: got q=%h co=%b z=%b want q=0 co=0 z=1",
               q, co, zero);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      nchecks++;
      if (q !== 4'h0) begin
        nerr++;
        $display("FAIL rst_low%0d: got q=%h want q=0", i, q);
      end
    end
    reset = 1'b1;
    tick();
    nchecks++;
    if (q !== 4'h1) begin
      nerr++;
      $display("FAIL inc_after_rst: got q=%h want q=1", q);
    end
  endtask

  task automatic test_wide();
    #1;
    nchecks++;
    if ({q8, co8, zero8} !== {8'h06, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL w_reset: got q=%h co=%b z=%b want q=06 co=0 z=0",
               q8, co8, zero8);
    end
    reset8 = 1'b1; en8 = 1'b1; mode8 = 3'b001; d8 = 8'hA5;
    tick();
    nchecks++;
    if (q8 !== 8'hA5) begin
      nerr++;
      $display("FAIL w_load: got q=%h want q=a5", q8);
    end
    clr8 = 1'b1;
    tick();
    nchecks++;
    if ({q8, co8} !== {8'h06, 1'b0}) begin
      nerr++;
      $display("FAIL w_clr: got q=%h co=%b want q=06 co=0", q8, co8);
    end
    clr8 = 1'b0; mode8 = 3'b110;
    tick();
    nchecks++;
    if ({q8, co8} !== {8'h07, 1'b0}) begin
      nerr++;
      $display("FAIL w_inc: got q=%h co=%b want q=07 co=0", q8, co8);
    end
    mode8 = 3'b001; d8 = 8'h00;
    tick();
    mode8 = 3'b111;
    tick();
    nchecks++;
    if ({q8, co8, zero8} !== {8'hFF, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL w_dec_wrap: got q=%h co=%b z=%b want q=ff co=1 z=0",
               q8, co8, zero8);
    end
    #2;
    reset8 = 1'b0;
    #1;
    nchecks++;
    if ({q8, co8} !== {8'h06, 1'b0}) begin
      nerr++;
      $display("FAIL w_async_rst: got q=%h co=%b want q=06 co=0", q8, co8);
    end
    reset8 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_shift();
    test_rotate();
    test_count();
    test_async_reset();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
